// File: rtl/hdmi_audio_pacer.sv
// Fractional-rate audio clock (phase accumulator) plus frame FIFO feeding
// the HDMI core one sample frame per audio period.
module hdmi_audio_pacer #(
    parameter int unsigned CLK_HZ       = 32000000,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [1:0]                         rate_sel,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   in_data,
    output logic                               clk_audio,
    output logic                               sample_stb,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0]   audio_word,
    output logic [$clog2(DEPTH):0]             level,
    output logic [7:0]                         underrun_cnt,
    input  logic                               underrun_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned W  = CHANNELS * SAMPLE_WIDTH;

    logic [31:0]   acc_q;
    logic [31:0]   rate_q;
    logic [31:0]   rate_dec;
    logic [31:0]   sum;
    logic          clk_audio_q;
    logic          stb_q;
    logic [W-1:0]  word_q;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    ur_q, ur_d;
    logic [AW-1:0] rd_q, wr_q;
    logic [W-1:0]  mem [DEPTH];

    logic toggle, rise, fall;
    logic full, empty, push, pop;

    // Two toggles per audio period, so the accumulator advances by 2*rate.
    assign sum    = acc_q + (rate_q << 1);
    assign toggle = sum >= 32'(CLK_HZ);
    assign rise   = toggle && !clk_audio_q;
    assign fall   = toggle && clk_audio_q;

    assign full     = level_q == (AW+1)'(DEPTH);
    assign empty    = level_q == '0;
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = fall && !empty;

    always_comb begin
        rate_dec = 32'd48000;
        unique case (rate_sel)
            2'd0: rate_dec = 32'd48000;
            2'd1: rate_dec = 32'd44100;
            2'd2: rate_dec = 32'd32000;
            2'd3: rate_dec = 32'd96000;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (!push && pop)
            level_d = level_q - 1'b1;
    end

    // Clear wins over a coincident underrun.
    always_comb begin
        ur_d = ur_q;
        if (fall && empty && ur_q != 8'hff)
            ur_d = ur_q + 8'd1;
        if (underrun_clr)
            ur_d = 8'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            rate_q      <= 32'd48000;
            clk_audio_q <= 1'b0;
            stb_q       <= 1'b0;
            word_q      <= '0;
            level_q     <= '0;
            ur_q        <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
        end else begin
            acc_q   <= toggle ? sum - 32'(CLK_HZ) : sum;
            stb_q   <= rise;
            level_q <= level_d;
            ur_q    <= ur_d;
            if (toggle)
                clk_audio_q <= !clk_audio_q;
            if (fall)
                rate_q <= rate_dec;
            if (pop) begin
                word_q <= mem[rd_q];
                rd_q   <= rd_q + 1'b1;
            end
            if (push)
                wr_q <= wr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_q] <= in_data;
    end

    assign clk_audio    = clk_audio_q;
    assign sample_stb   = stb_q;
    assign audio_word   = word_q;
    assign level        = level_q;
    assign underrun_cnt = ur_q;

endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// Randomized self-checking bench for hdmi_audio_pacer against a
// closed-form toggle model and a queue-based FIFO model.
module tb_hdmi_audio_pacer;

    localparam int unsigned CLK   = 1000000;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rate_sel = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        clk_audio;
    logic        sample_stb;
    logic [31:0] audio_word;
    logic [3:0]  level;
    logic [7:0]  underrun_cnt;
    logic        underrun_clr = 1'b0;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hdmi_audio_pacer #(
        .CLK_HZ(CLK), .CHANNELS(2), .SAMPLE_WIDTH(16), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .rate_sel(rate_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .clk_audio(clk_audio), .sample_stb(sample_stb),
        .audio_word(audio_word), .level(level),
        .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr)
    );

    // Cycle index since reset release: first edge after release is 1.
    int unsigned cyc;
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    // Toggle count after n cycles at a constant 48 kHz since reset.
    function automatic longint tg(longint n);
        return (n * 64'd96000) / longint'(CLK);
    endfunction

    function automatic bit is_fall(longint n);
        if (n < 1) return 1'b0;
        return (tg(n) != tg(n-1)) && ((tg(n) % 2) == 0);
    endfunction

    logic [31:0] mq[$];
    logic [31:0] m_word;
    int          m_ur;
    bit          m_fell;
    bit          m_push;

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; underrun_clr = 1'b0; rate_sel = 2'd0;
        mq.delete(); m_word = '0; m_ur = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One cycle at 48 kHz: drive, clock, then advance the model.
    task automatic step(input bit v, input logic [31:0] d, input bit clr);
        @(negedge clk);
        in_valid = v; in_data = d; underrun_clr = clr;
        m_push = v && (mq.size() < DEPTH);
        @(posedge clk); #1;
        m_fell = is_fall(cyc);
        if (m_fell) begin
            if (mq.size() > 0) m_word = mq.pop_front();
            else if (m_ur < 255) m_ur++;
        end
        if (clr) m_ur = 0;
        if (m_push) mq.push_back(d);
        in_valid = 1'b0; underrun_clr = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); reset = 1'b1; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        tests_run++;
        if (clk_audio !== 1'b0 || sample_stb !== 1'b0) begin
            fails++; $display("FAIL reset_clk: got %0b/%0b want 0/0", clk_audio, sample_stb);
        end
        tests_run++;
        if (audio_word !== 32'h0 || level !== 4'd0 || underrun_cnt !== 8'd0) begin
            fails++; $display("FAIL reset_state: got %h/%0d/%0d want 0/0/0", audio_word, level, underrun_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0; #1;
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_rate48;
        int mism = 0, bad = 0, cnt = 0;
        longint n = 0, first = 0, last = 0, len;
        logic prev = 1'b0;
        bit ca, st;
        longint lo = CLK / 96000;
        longint hi = (CLK + 95999) / 96000;
        do_reset();
        repeat (20000) begin
            @(posedge clk); #1;
            n = cyc;
            ca = (tg(n) % 2) == 1;
            st = (tg(n) != tg(n-1)) && ca;
            if (clk_audio !== ca || sample_stb !== st) mism++;
            if (sample_stb === 1'b1) cnt++;
            if (clk_audio !== prev) begin
                if (first == 0) first = n;
                len = n - last;
                if (last != 0 && (len < lo || len > hi)) bad++;
                last = n; prev = clk_audio;
            end
        end
        tests_run++;
        if (mism != 0) begin fails++; $display("FAIL r48_trace: got %0d mismatching cycles want 0", mism); end
        tests_run++;
        if (cnt != (tg(n) + 1) / 2) begin fails++; $display("FAIL r48_pulses: got %0d want %0d", cnt, (tg(n)+1)/2); end
        tests_run++;
        if (first != hi) begin fails++; $display("FAIL r48_first_toggle: got %0d want %0d", first, hi); end
        tests_run++;
        if (bad != 0) begin fails++; $display("FAIL r48_phase_len: got %0d bad phases want 0", bad); end
    endtask

    task automatic test_rate_change;
        int k, cnt = 0, bad = 0;
        longint last, len, t_rise, exp_cnt;
        logic prev;
        bit ok;
        do_reset();
        rate_sel = 2'd1;
        prev = 1'b0; ok = 0;
        for (k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #1;
            if (prev === 1'b1 && clk_audio === 1'b0) ok = 1;
            prev = clk_audio;
        end
        tests_run++;
        if (!ok) begin fails++; $display("FAIL r441_first_fall: got timeout want fall"); end
        last = cyc;
        for (k = 0; k < 40000; k++) begin
            @(posedge clk); #1;
            if (sample_stb === 1'b1) cnt++;
            if (clk_audio !== prev) begin
                len = cyc - last;
                if (len < 11 || len > 12) bad++;
                last = cyc; prev = clk_audio;
            end
        end
        exp_cnt = 40000 * 44100 / CLK;
        tests_run++;
        if (cnt < exp_cnt - 1 || cnt > exp_cnt + 1) begin
            fails++; $display("FAIL r441_pulses: got %0d want %0d+-1", cnt, exp_cnt);
        end
        tests_run++;
        if (bad != 0) begin fails++; $display("FAIL r441_phase_len: got %0d bad phases want 0", bad); end
        ok = 0;
        for (k = 0; k < 50 && !ok; k++) begin
            @(posedge clk); #1;
            if (prev === 1'b0 && clk_audio === 1'b1) ok = 1;
            prev = clk_audio;
        end
        t_rise = cyc;
        repeat (3) @(negedge clk);
        rate_sel = 2'd3;
        ok = 0;
        for (k = 0; k < 50 && !ok; k++) begin
            @(posedge clk); #1;
            if (prev === 1'b1 && clk_audio === 1'b0) ok = 1;
            prev = clk_audio;
        end
        len = cyc - t_rise;
        tests_run++;
        if (!ok || len < 11 || len > 12) begin
            fails++; $display("FAIL rate_change_high: got %0d cycles want 11..12", len);
        end
        last = cyc; bad = 0;
        for (int p = 0; p < 6; p++) begin
            ok = 0;
            for (k = 0; k < 50 && !ok; k++) begin
                @(posedge clk); #1;
                if (clk_audio !== prev) ok = 1;
                prev = clk_audio;
            end
            len = cyc - last;
            if (!ok || len < 5 || len > 6) bad++;
            last = cyc;
        end
        tests_run++;
        if (bad != 0) begin fails++; $display("FAIL r96_phase_len: got %0d bad phases want 0", bad); end
    endtask

    task automatic test_ordering;
        logic [31:0] words[$];
        logic [31:0] want;
        int i = 1, k = 0, mism = 0;
        longint t9 = 0, first_pop = 0;
        do_reset();
        while (words.size() < 9 && k < 1000) begin
            step(i <= 9, {16'(i), 16'(i)}, 1'b0);
            k++;
            if (m_push) begin
                if (i == 8) begin
                    tests_run++;
                    if (level !== 4'd8 || in_ready !== 1'b0) begin
                        fails++; $display("FAIL order_full: got level %0d ready %0b want 8/0", level, in_ready);
                    end
                end
                if (i == 9) t9 = cyc;
                i++;
            end
            if (m_fell) begin
                if (first_pop == 0) first_pop = cyc;
                words.push_back(audio_word);
            end
            if (level !== 4'(mq.size()) || audio_word !== m_word) mism++;
        end
        tests_run++;
        if (t9 != first_pop + 1) begin fails++; $display("FAIL order_9th_accept: got cycle %0d want %0d", t9, first_pop + 1); end
        tests_run++;
        if (mism != 0) begin fails++; $display("FAIL order_scoreboard: got %0d mismatches want 0", mism); end
        tests_run++;
        if (words.size() != 9) begin
            fails++; $display("FAIL order_count: got %0d words want 9", words.size());
        end else begin
            for (int j = 0; j < 9; j++) begin
                want = {16'(j + 1), 16'(j + 1)};
                tests_run++;
                if (words[j] !== want) begin fails++; $display("FAIL order_word%0d: got %h want %h", j, words[j], want); end
            end
        end
    endtask

    task automatic test_underrun;
        int falls = 0, k = 0, mism = 0;
        logic [31:0] d;
        do_reset();
        while (falls < 300 && k < 10000) begin
            step(1'b0, '0, 1'b0);
            k++;
            if (m_fell) falls++;
            if (audio_word !== 32'h0) mism++;
        end
        tests_run++;
        if (falls != 300) begin fails++; $display("FAIL underrun_periods: got %0d want 300", falls); end
        tests_run++;
        if (mism != 0) begin fails++; $display("FAIL underrun_word: got %0d nonzero cycles want 0", mism); end
        tests_run++;
        if (underrun_cnt !== 8'd255) begin fails++; $display("FAIL underrun_sat: got %0d want 255", underrun_cnt); end
        step(1'b0, '0, 1'b1);
        tests_run++;
        if (underrun_cnt !== 8'd0) begin fails++; $display("FAIL underrun_clr: got %0d want 0", underrun_cnt); end
        if (is_fall(cyc + 1)) step(1'b0, '0, 1'b0);
        d = $urandom;
        step(1'b1, d, 1'b0);
        tests_run++;
        if (level !== 4'd1) begin fails++; $display("FAIL underrun_push_level: got %0d want 1", level); end
        k = 0;
        do begin step(1'b0, '0, 1'b0); k++; end while (!m_fell && k < 40);
        tests_run++;
        if (audio_word !== d || level !== 4'd0) begin
            fails++; $display("FAIL underrun_pop: got %h/%0d want %h/0", audio_word, level, d);
        end
    endtask

    task automatic test_edge;
        int k;
        logic [31:0] d0;
        do_reset();
        k = 0;
        while (!is_fall(cyc + 1) && k < 100) begin step(1'b0, '0, 1'b0); k++; end
        d0 = $urandom;
        step(1'b1, d0, 1'b0);
        tests_run++;
        if (!m_fell || underrun_cnt !== 8'(m_ur) || m_ur != 1 || level !== 4'd1) begin
            fails++; $display("FAIL edge_empty_pushpop: got ur %0d lvl %0d want 1/1", underrun_cnt, level);
        end
        repeat (3) step(1'b1, $urandom, 1'b0);
        tests_run++;
        if (level !== 4'(mq.size()) || mq.size() != 4) begin
            fails++; $display("FAIL edge_fill4: got %0d want 4", level);
        end
        k = 0;
        while (!is_fall(cyc + 1) && k < 100) begin step(1'b0, '0, 1'b0); k++; end
        step(1'b1, $urandom, 1'b0);
        tests_run++;
        if (!m_fell || level !== 4'd4 || audio_word !== d0) begin
            fails++; $display("FAIL edge_full_pushpop: got lvl %0d word %h want 4/%h", level, audio_word, d0);
        end
        do_reset();
        k = 0;
        while (!is_fall(cyc + 1) && k < 100) begin step(1'b0, '0, 1'b0); k++; end
        step(1'b0, '0, 1'b1);
        tests_run++;
        if (!m_fell || underrun_cnt !== 8'd0) begin
            fails++; $display("FAIL edge_clr_vs_underrun: got %0d want 0", underrun_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int k = 0;
        longint first = 0;
        logic [31:0] d;
        do_reset();
        repeat (6) begin d = $urandom; step(1'b1, d, 1'b0); end
        while (!((tg(cyc) % 2) == 1 && mq.size() == 5) && k < 200) begin
            step(1'b0, '0, 1'b0); k++;
        end
        tests_run++;
        if (level !== 4'd5 || clk_audio !== 1'b1 || audio_word !== m_word) begin
            fails++; $display("FAIL rmid_setup: got lvl %0d ca %0b want 5/1", level, clk_audio);
        end
        @(negedge clk); reset = 1'b1; #1;
        mq.delete(); m_word = '0; m_ur = 0;
        tests_run++;
        if (clk_audio !== 1'b0 || level !== 4'd0 || in_ready !== 1'b0 || audio_word !== 32'h0) begin
            fails++; $display("FAIL rmid_async: got ca %0b lvl %0d rdy %0b word %h want 0/0/0/0",
                              clk_audio, level, in_ready, audio_word);
        end
        @(negedge clk); reset = 1'b0;
        for (k = 0; k < 50 && first == 0; k++) begin
            @(posedge clk); #1;
            if (clk_audio === 1'b1) first = cyc;
        end
        tests_run++;
        if (first != (CLK + 95999) / 96000) begin
            fails++; $display("FAIL rmid_first_rise: got %0d want %0d", first, (CLK + 95999) / 96000);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rate48();
        test_rate_change();
        test_ordering();
        test_underrun();
        test_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
